// File: rtl/dcache_refill_unit.sv
// dcache_refill_unit
//   Services load-queue requests that missed the data cache. A cached request
//   becomes a 16-beat line fill into the 2-way data BRAM. Before the fill, the
//   victim tag is invalidated. After the fill, the tag is validated. An uncached
//   request becomes a single bus read whose result is returned right-justified.
// Ports
//   core_clock_i / core_reset_ni : clock, asynchronous active-low reset
//   dc_req, dc_addr, dc_op, dc_uncached : request from the load queue
//   dc_data, dc_cmp              : uncached result and one-cycle completion pulse
//   mem_req_o .. mem_rdata_i     : memory bus read channel
//   bram_wr_*                    : data BRAM write port {way, index, beat}
//   tag_wr_*                     : tag array write port
//   busy_o                       : controller is not idle
module dcache_refill_unit #(
   parameter int INDEX_W = 5,
   parameter int BEAT_W  = 4,
   parameter int TAG_W   = 19
) (
   input  logic                       core_clock_i,
   input  logic                       core_reset_ni,
   input  logic                       dc_req,
   input  logic [31:0]                dc_addr,
   input  logic [1:0]                 dc_op,
   input  logic                       dc_uncached,
   output logic [31:0]                dc_data,
   output logic                       dc_cmp,
   output logic                       mem_req_o,
   output logic [31:0]                mem_addr_o,
   output logic [BEAT_W-1:0]          mem_len_o,
   output logic [1:0]                 mem_size_o,
   input  logic                       mem_gnt_i,
   input  logic                       mem_rvalid_i,
   input  logic [63:0]                mem_rdata_i,
   output logic                       bram_wr_en_o,
   output logic [INDEX_W+BEAT_W:0]    bram_wr_addr_o,
   output logic [63:0]                bram_wr_data_o,
   output logic                       tag_wr_en_o,
   output logic                       tag_wr_way_o,
   output logic [INDEX_W-1:0]         tag_wr_index_o,
   output logic [TAG_W-1:0]           tag_wr_tag_o,
   output logic                       tag_wr_valid_o,
   output logic                       busy_o
);

   // Byte offset within a line: beats x 8 bytes.
   localparam int OFF_W = BEAT_W + 3;

   typedef enum logic [2:0] {
      IDLE, UC_REQ, UC_WAIT, INV, FILL_REQ, FILL_DATA, FILL_TAG, DONE
   } state_e;

   state_e                    state_q, state_d;
   logic [2:0]                boff_q, boff_d;
   logic [1:0]                op_q, op_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic [(1<<INDEX_W)-1:0]   repl_q, repl_d;
   logic [31:0]               dc_data_q, dc_data_d;
   logic                      dc_cmp_q, dc_cmp_d;
   logic                      mem_req_q, mem_req_d;
   logic [31:0]               mem_addr_q, mem_addr_d;
   logic [BEAT_W-1:0]         mem_len_q, mem_len_d;
   logic [1:0]                mem_size_q, mem_size_d;
   logic                      bram_wr_en_q, bram_wr_en_d;
   logic [INDEX_W+BEAT_W:0]   bram_wr_addr_q, bram_wr_addr_d;
   logic [63:0]               bram_wr_data_q, bram_wr_data_d;
   logic                      tag_wr_en_q, tag_wr_en_d;
   logic                      tag_wr_way_q, tag_wr_way_d;
   logic [INDEX_W-1:0]        tag_wr_index_q, tag_wr_index_d;
   logic [TAG_W-1:0]          tag_wr_tag_q, tag_wr_tag_d;
   logic                      tag_wr_valid_q, tag_wr_valid_d;
   logic                      busy_q, busy_d;

   // Shift the addressed bytes down to bit 0 and zero everything above the access size.
   function automatic logic [31:0] uc_extract(input logic [63:0] rdata,
                                              input logic [2:0]  boff,
                                              input logic [1:0]  size);
      logic [63:0] sh;
      sh = rdata >> {boff, 3'b000};
      case (size)
         2'd0:    return {24'd0, sh[7:0]};
         2'd1:    return {16'd0, sh[15:0]};
         default: return sh[31:0];
      endcase
   endfunction

   always_comb begin
      state_d        = state_q;
      boff_d         = boff_q;
      op_d           = op_q;
      beat_d         = beat_q;
      repl_d         = repl_q;
      dc_data_d      = dc_data_q;
      dc_cmp_d       = 1'b0;
      mem_req_d      = mem_req_q;
      mem_addr_d     = mem_addr_q;
      mem_len_d      = mem_len_q;
      mem_size_d     = mem_size_q;
      bram_wr_en_d   = 1'b0;
      bram_wr_addr_d = bram_wr_addr_q;
      bram_wr_data_d = bram_wr_data_q;
      tag_wr_en_d    = 1'b0;
      tag_wr_way_d   = tag_wr_way_q;
      tag_wr_index_d = tag_wr_index_q;
      tag_wr_tag_d   = tag_wr_tag_q;
      tag_wr_valid_d = tag_wr_valid_q;

      case (state_q)
         IDLE: begin
            if (dc_req) begin
               boff_d = dc_addr[2:0];
               op_d   = dc_op;
               beat_d = '0;
               if (dc_uncached) begin
                  state_d    = UC_REQ;
                  mem_req_d  = 1'b1;
                  mem_addr_d = dc_addr;
                  mem_len_d  = '0;
                  mem_size_d = dc_op;
               end else begin
                  // The way/index/tag chosen here stay in the tag port flops and
                  // address the whole fill; the invalidate goes out during INV.
                  state_d        = INV;
                  mem_addr_d     = {dc_addr[31:OFF_W], {OFF_W{1'b0}}};
                  mem_len_d      = '1;
                  mem_size_d     = 2'd3;
                  tag_wr_en_d    = 1'b1;
                  tag_wr_valid_d = 1'b0;
                  tag_wr_way_d   = repl_q[dc_addr[OFF_W +: INDEX_W]];
                  tag_wr_index_d = dc_addr[OFF_W +: INDEX_W];
                  tag_wr_tag_d   = dc_addr[OFF_W+INDEX_W +: TAG_W];
               end
            end
         end
         INV: begin
            state_d   = FILL_REQ;
            mem_req_d = 1'b1;
         end
         UC_REQ, FILL_REQ: begin
            if (mem_gnt_i) begin
               mem_req_d = 1'b0;
               state_d   = (state_q == UC_REQ) ? UC_WAIT : FILL_DATA;
            end
         end
         FILL_DATA: begin
            if (mem_rvalid_i) begin
               bram_wr_en_d   = 1'b1;
               bram_wr_addr_d = {tag_wr_way_q, tag_wr_index_q, beat_q};
               bram_wr_data_d = mem_rdata_i;
               beat_d         = beat_q + 1'b1;
               if (beat_q == '1) begin
                  state_d                = FILL_TAG;
                  tag_wr_en_d            = 1'b1;
                  tag_wr_valid_d         = 1'b1;
                  repl_d[tag_wr_index_q] = ~repl_q[tag_wr_index_q];
                  dc_cmp_d               = 1'b1;
               end
            end
         end
         UC_WAIT: begin
            if (mem_rvalid_i) begin
               dc_data_d = uc_extract(mem_rdata_i, boff_q, op_q);
               dc_cmp_d  = 1'b1;
               state_d   = DONE;
            end
         end
         FILL_TAG: state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
      if (!core_reset_ni) begin
         state_q        <= IDLE;
         boff_q         <= '0;
         op_q           <= '0;
         beat_q         <= '0;
         repl_q         <= '0;
         dc_data_q      <= '0;
         dc_cmp_q       <= 1'b0;
         mem_req_q      <= 1'b0;
         mem_addr_q     <= '0;
         mem_len_q      <= '0;
         mem_size_q     <= '0;
         bram_wr_en_q   <= 1'b0;
         bram_wr_addr_q <= '0;
         bram_wr_data_q <= '0;
         tag_wr_en_q    <= 1'b0;
         tag_wr_way_q   <= 1'b0;
         tag_wr_index_q <= '0;
         tag_wr_tag_q   <= '0;
         tag_wr_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         boff_q         <= boff_d;
         op_q           <= op_d;
         beat_q         <= beat_d;
         repl_q         <= repl_d;
         dc_data_q      <= dc_data_d;
         dc_cmp_q       <= dc_cmp_d;
         mem_req_q      <= mem_req_d;
         mem_addr_q     <= mem_addr_d;
         mem_len_q      <= mem_len_d;
         mem_size_q     <= mem_size_d;
         bram_wr_en_q   <= bram_wr_en_d;
         bram_wr_addr_q <= bram_wr_addr_d;
         bram_wr_data_q <= bram_wr_data_d;
         tag_wr_en_q    <= tag_wr_en_d;
         tag_wr_way_q   <= tag_wr_way_d;
         tag_wr_index_q <= tag_wr_index_d;
         tag_wr_tag_q   <= tag_wr_tag_d;
         tag_wr_valid_q <= tag_wr_valid_d;
         busy_q         <= busy_d;
      end
   end

   assign dc_data        = dc_data_q;
   assign dc_cmp         = dc_cmp_q;
   assign mem_req_o      = mem_req_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_len_o      = mem_len_q;
   assign mem_size_o     = mem_size_q;
   assign bram_wr_en_o   = bram_wr_en_q;
   assign bram_wr_addr_o = bram_wr_addr_q;
   assign bram_wr_data_o = bram_wr_data_q;
   assign tag_wr_en_o    = tag_wr_en_q;
   assign tag_wr_way_o   = tag_wr_way_q;
   assign tag_wr_index_o = tag_wr_index_q;
   assign tag_wr_tag_o   = tag_wr_tag_q;
   assign tag_wr_valid_o = tag_wr_valid_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Testbench for dcache_refill_unit: uncached loads, line fills, replacement,
// slow bus handshakes, stray beats and reset in the middle of a fill.
module tb_dcache_refill_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dc_req = 1'b0;
   logic [31:0] dc_addr = '0;
   logic [1:0]  dc_op = '0;
   logic        dc_uncached = 1'b0;
   logic [31:0] dc_data;
   logic        dc_cmp;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_len_o;
   logic [1:0]  mem_size_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [63:0] mem_rdata_i = '0;
   logic        bram_wr_en_o;
   logic [9:0]  bram_wr_addr_o;
   logic [63:0] bram_wr_data_o;
   logic        tag_wr_en_o;
   logic        tag_wr_way_o;
   logic [4:0]  tag_wr_index_o;
   logic [18:0] tag_wr_tag_o;
   logic        tag_wr_valid_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   // Scoreboards: {bram addr, data} per beat, and uncached results.
   logic [73:0] bram_q[$];
   logic [31:0] uc_q[$];

   always #5 clk = ~clk;

   dcache_refill_unit dut (
      .core_clock_i   (clk),
      .core_reset_ni  (rst_n),
      .dc_req         (dc_req),
      .dc_addr        (dc_addr),
      .dc_op          (dc_op),
      .dc_uncached    (dc_uncached),
      .dc_data        (dc_data),
      .dc_cmp         (dc_cmp),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_len_o      (mem_len_o),
      .mem_size_o     (mem_size_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .bram_wr_en_o   (bram_wr_en_o),
      .bram_wr_addr_o (bram_wr_addr_o),
      .bram_wr_data_o (bram_wr_data_o),
      .tag_wr_en_o    (tag_wr_en_o),
      .tag_wr_way_o   (tag_wr_way_o),
      .tag_wr_index_o (tag_wr_index_o),
      .tag_wr_tag_o   (tag_wr_tag_o),
      .tag_wr_valid_o (tag_wr_valid_o),
      .busy_o         (busy_o)
   );

   function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
      return {a ^ 32'h5A5A_A5A5, 24'hC0FFEE, 8'(b * 17 + 1)};
   endfunction

   // Uncached request; inputs change on the falling edge, outputs sampled there too.
   task automatic do_uc(input string nm, input logic [31:0] addr, input logic [1:0] op,
                        input logic [63:0] rdata, input logic [31:0] exp,
                        input int gnt_dly, input int exp_lat);
      int cyc = 0, req_cyc = 0, cmp_cnt = 0, phase = 0, done_cyc = -1;
      logic fin = 1'b0;
      logic [31:0] e;
      uc_q.delete();
      dc_req = 1'b1; dc_addr = addr; dc_op = op; dc_uncached = 1'b1;
      while (!fin && cyc < 200) begin
         @(negedge clk); cyc++;
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
         if (dc_cmp) begin
            cmp_cnt++;
            checks++;
            if (uc_q.size() == 0) begin
               errors++; $display("FAIL %s unexpected dc_cmp at cycle %0d", nm, cyc);
            end else begin
               e = uc_q.pop_front();
               if (dc_data !== e) begin
                  errors++; $display("FAIL %s dc_data got %h exp %h", nm, dc_data, e);
               end
            end
            if (cmp_cnt == 1) begin
               dc_req = 1'b0; done_cyc = cyc;
               if (exp_lat > 0) begin
                  checks++;
                  if (cyc != exp_lat) begin
                     errors++; $display("FAIL %s latency got %0d exp %0d", nm, cyc, exp_lat);
                  end
               end
            end
         end
         if (phase == 0 && mem_req_o) begin
            if (req_cyc == 0) begin
               checks++;
               if ({mem_addr_o, mem_len_o, mem_size_o} !== {addr, 4'd0, op}) begin
                  errors++; $display("FAIL %s bus req got %h/%0d/%0d exp %h/0/%0d",
                                     nm, mem_addr_o, mem_len_o, mem_size_o, addr, op);
               end
            end
            req_cyc++;
            if (req_cyc > gnt_dly) begin mem_gnt_i = 1'b1; phase = 1; end
         end else if (phase == 1) begin
            checks++;
            if (mem_req_o !== 1'b0) begin
               errors++; $display("FAIL %s mem_req_o got %b exp 0 after grant", nm, mem_req_o);
            end
            mem_rvalid_i = 1'b1; mem_rdata_i = rdata; uc_q.push_back(exp); phase = 2;
         end
         if (done_cyc > 0 && cyc == done_cyc + 2) fin = 1'b1;
      end
      checks++;
      if (!fin || cmp_cnt != 1) begin
         errors++; $display("FAIL %s dc_cmp pulses got %0d exp 1 (finished %b)", nm, cmp_cnt, fin);
      end
      checks++;
      if (busy_o !== 1'b0 || dc_data !== exp) begin
         errors++; $display("FAIL %s after done busy %b data %h exp busy 0 data %h", nm, busy_o, dc_data, exp);
      end
      dc_req = 1'b0; dc_uncached = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
   endtask

   // Line fill; stop_beats < 16 returns once that many beats have been written.
   task automatic do_fill(input string nm, input logic [31:0] addr, input int gnt_dly,
                          input int gap, input logic exp_way, input int stop_beats);
      int cyc = 0, req_cyc = 0, phase = 0, sent = 0, seen = 0, gap_cnt = 0;
      int cmp_cnt = 0, inv_cnt = 0, tag_cnt = 0, done_cyc = -1;
      logic fin = 1'b0;
      logic [4:0]  idx;
      logic [18:0] tag;
      logic [73:0] e;
      idx = addr[11:7];
      tag = addr[30:12];
      bram_q.delete();
      dc_req = 1'b1; dc_addr = addr; dc_uncached = 1'b0; dc_op = 2'd0;
      while (!fin && cyc < 600) begin
         @(negedge clk); cyc++;
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
         if (cyc == 2) dc_addr = ~addr;
         if (bram_wr_en_o) begin
            checks++;
            if (bram_q.size() == 0) begin
               errors++; $display("FAIL %s unexpected bram write addr %h", nm, bram_wr_addr_o);
            end else begin
               e = bram_q.pop_front(); seen++;
               if ({bram_wr_addr_o, bram_wr_data_o} !== e) begin
                  errors++; $display("FAIL %s bram write got %h:%h exp %h:%h", nm,
                                     bram_wr_addr_o, bram_wr_data_o, e[73:64], e[63:0]);
               end
            end
         end
         if (tag_wr_en_o) begin
            checks++;
            if (!tag_wr_valid_o) begin
               inv_cnt++;
               if ({tag_wr_way_o, tag_wr_index_o, tag_wr_tag_o} !== {exp_way, idx, tag} || cyc != 1) begin
                  errors++; $display("FAIL %s invalidate got way %b idx %h tag %h cyc %0d exp way %b idx %h tag %h cyc 1",
                                     nm, tag_wr_way_o, tag_wr_index_o, tag_wr_tag_o, cyc, exp_way, idx, tag);
               end
            end else begin
               tag_cnt++;
               if ({tag_wr_way_o, tag_wr_index_o, tag_wr_tag_o} !== {exp_way, idx, tag} || seen != 16) begin
                  errors++; $display("FAIL %s tag write got way %b idx %h tag %h beats %0d exp way %b idx %h tag %h beats 16",
                                     nm, tag_wr_way_o, tag_wr_index_o, tag_wr_tag_o, seen, exp_way, idx, tag);
               end
            end
         end
         if (dc_cmp) begin
            cmp_cnt++;
            checks++;
            if (seen != 16 || tag_cnt != 1 || cmp_cnt != 1) begin
               errors++; $display("FAIL %s dc_cmp pulse %0d with beats %0d tags %0d exp first pulse at 16 beats 1 tag",
                                  nm, cmp_cnt, seen, tag_cnt);
            end
            if (cmp_cnt == 1) begin dc_req = 1'b0; done_cyc = cyc; end
         end
         if (stop_beats < 16 && sent == stop_beats && bram_q.size() == 0) begin
            fin = 1'b1;
         end else begin
            if (phase == 0 && mem_req_o) begin
               if (req_cyc == 0) begin
                  checks++;
                  if ({mem_addr_o, mem_len_o, mem_size_o} !== {addr[31:7], 7'd0, 4'd15, 2'd3}) begin
                     errors++; $display("FAIL %s bus req got %h/%0d/%0d exp %h/15/3",
                                        nm, mem_addr_o, mem_len_o, mem_size_o, {addr[31:7], 7'd0});
                  end
               end
               req_cyc++;
               if (req_cyc > gnt_dly) begin mem_gnt_i = 1'b1; phase = 1; end
            end else if (phase == 1) begin
               checks++;
               if (mem_req_o !== 1'b0) begin
                  errors++; $display("FAIL %s mem_req_o got %b exp 0 after grant", nm, mem_req_o);
               end
               phase = 2; gap_cnt = 0;
            end
            if (phase == 2 && sent < 16) begin
               if (gap_cnt == 0) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = beat_data(addr, sent);
                  bram_q.push_back({exp_way, idx, 4'(sent), beat_data(addr, sent)});
                  sent++; gap_cnt = gap;
               end else begin
                  gap_cnt--;
               end
            end
            if (done_cyc > 0 && cyc == done_cyc + 2) fin = 1'b1;
         end
      end
      mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
      checks++;
      if (!fin) begin
         errors++; $display("FAIL %s timeout after %0d cycles, beats sent %0d seen %0d", nm, cyc, sent, seen);
      end else if (stop_beats >= 16) begin
         if (cmp_cnt != 1 || inv_cnt != 1 || tag_cnt != 1 || seen != 16 || busy_o !== 1'b0) begin
            errors++; $display("FAIL %s counts cmp %0d inv %0d tag %0d beats %0d busy %b exp 1 1 1 16 0",
                               nm, cmp_cnt, inv_cnt, tag_cnt, seen, busy_o);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({dc_cmp, mem_req_o, bram_wr_en_o, tag_wr_en_o, tag_wr_valid_o, busy_o} !== 6'b0) begin
         errors++; $display("FAIL reset strobes got %b exp 000000",
                            {dc_cmp, mem_req_o, bram_wr_en_o, tag_wr_en_o, tag_wr_valid_o, busy_o});
      end
      checks++;
      if (dc_data !== 32'd0 || mem_addr_o !== 32'd0 || bram_wr_addr_o !== 10'd0) begin
         errors++; $display("FAIL reset values data %h addr %h bram %h exp 0", dc_data, mem_addr_o, bram_wr_addr_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_release busy got %b exp 0", busy_o);
      end
   endtask

   task automatic test_uncached();
      do_uc("uc_word", 32'h8000_0004, 2'd2, 64'h1122_3344_5566_7788, 32'h1122_3344, 0, 3);
      do_uc("uc_byte", 32'h8000_0003, 2'd0, 64'h1122_3344_5566_7788, 32'h0000_0055, 1, 0);
      do_uc("uc_byte7", 32'h8000_0007, 2'd0, 64'hF122_3344_5566_7788, 32'h0000_00F1, 0, 0);
      do_uc("uc_half", 32'h8000_0006, 2'd1, 64'h1122_3344_5566_7788, 32'h0000_1122, 2, 0);
   endtask

   task automatic test_fill();
      do_fill("fill_1", 32'h0000_1280, 0, 0, 1'b0, 16);
      checks++;
      if (dc_data !== 32'h0000_1122) begin
         errors++; $display("FAIL fill_hold dc_data got %h exp 00001122", dc_data);
      end
   endtask

   task automatic test_replacement();
      do_fill("fill_2_way1", 32'h0000_1280, 0, 0, 1'b1, 16);
      do_fill("fill_3_way0", 32'h0004_5280, 1, 1, 1'b0, 16);
   endtask

   task automatic test_slow_bus();
      do_fill("fill_slow", 32'h0000_2300, 5, 3, 1'b0, 16);
   endtask

   task automatic test_stray_rvalid();
      logic bad = 1'b0;
      mem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
      for (int i = 0; i < 4; i++) begin
         mem_rvalid_i = (i < 2);
         @(negedge clk);
         if (bram_wr_en_o || dc_cmp || busy_o || tag_wr_en_o) bad = 1'b1;
      end
      checks++;
      if (bad || dc_data !== 32'h0000_1122) begin
         errors++; $display("FAIL stray_rvalid reacted: seen %b data %h exp 0 00001122", bad, dc_data);
      end
      mem_rvalid_i = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      // Index 5 victim is way 1 at this point; reset must put it back to way 0.
      do_fill("fill_abort", 32'h0000_1280, 0, 0, 1'b1, 8);
      rst_n = 1'b0; dc_req = 1'b0; mem_rvalid_i = 1'b0;
      #1;
      checks++;
      if ({dc_cmp, mem_req_o, bram_wr_en_o, tag_wr_en_o, busy_o} !== 5'b0 || bram_wr_addr_o !== 10'd0) begin
         errors++; $display("FAIL mid_reset outputs got %b bram %h exp 00000 000",
                            {dc_cmp, mem_req_o, bram_wr_en_o, tag_wr_en_o, busy_o}, bram_wr_addr_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || bram_wr_en_o !== 1'b0) begin
         errors++; $display("FAIL mid_reset idle busy %b wr %b exp 0 0", busy_o, bram_wr_en_o);
      end
      do_fill("fill_after_reset", 32'h0000_1280, 0, 0, 1'b0, 16);
   endtask

   task automatic test_back_to_back();
      do_uc("b2b_uc", 32'h9000_0000, 2'd2, 64'hAAAA_BBBB_CCCC_DDDD, 32'hCCCC_DDDD, 0, 3);
      do_fill("b2b_fill", 32'h0000_1280, 0, 0, 1'b1, 16);
      do_uc("b2b_uc2", 32'h9000_0002, 2'd1, 64'hAAAA_BBBB_CCCC_DDDD, 32'h0000_CCCC, 0, 3);
   endtask

   initial begin
      test_reset();
      test_uncached();
      test_fill();
      test_replacement();
      test_slow_bus();
      test_stray_rvalid();
      test_reset_mid_fill();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
